// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchronizer and release sequencer.
// An async active-high reset is synchronized through NUM_STG flops. The
// NUM_CH outputs are then released one at a time, GAP cycles apart,
// starting with bit 0.
// Optional feature macro: RST_SEQ_SW_REQ_EN. It adds the sw_rst_req port
// and the HOLD state, which re-run the release sequence on request.
module rst_seq_sync #(
    parameter int NUM_STG = 2,
    parameter int NUM_CH  = 4,
    parameter int GAP     = 8,
    parameter int SW_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RST_SEQ_SW_REQ_EN
    input  logic              sw_rst_req,
`endif
    output logic [NUM_CH-1:0] sync_rst,
    output logic              rst_done
);

`ifdef RST_SEQ_SW_REQ_EN
    localparam int MAXC = (GAP > SW_HOLD) ? GAP : SW_HOLD;
`else
    localparam int MAXC = GAP;
`endif
    localparam int CW  = $clog2(MAXC + 1);
    localparam int CHW = $clog2(NUM_CH + 1);

    localparam logic [CW-1:0]  GAP_M1  = CW'(GAP - 1);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
`ifdef RST_SEQ_SW_REQ_EN
    localparam logic [CW-1:0]  SWH_M1  = CW'(SW_HOLD - 1);
`endif

    // Reject illegal parameter sets at elaboration.
    if (NUM_STG < 2 || NUM_STG > 4 || NUM_CH < 1 || NUM_CH > 16 ||
        GAP < 1 || SW_HOLD < 1) begin : g_bad_param
        $error("rst_seq_sync: illegal parameter value");
    end

`ifdef RST_SEQ_SW_REQ_EN
    typedef enum logic [1:0] {SYNC, RELEASE, DONE, HOLD} state_t;
`else
    typedef enum logic [1:0] {SYNC, RELEASE, DONE} state_t;
`endif

    logic [NUM_STG-1:0] sync_q;
    logic               rst_s;
    state_t             state, state_n;
    logic [CHW-1:0]     ch, ch_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [NUM_CH-1:0]  rel_n;
    logic               done_n;
    logic               start;

    // Synchronizer chain: set asynchronously, shifts zeros in once rst drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[NUM_STG-2:0], 1'b0};
    end

    assign rst_s = sync_q[NUM_STG-1];

    // Sequencer state and registered outputs; all cleared by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            ch       <= '0;
            cnt      <= '0;
            sync_rst <= '1;
            rst_done <= 1'b0;
        end else begin
            state    <= state_n;
            ch       <= ch_n;
            cnt      <= cnt_n;
            sync_rst <= rel_n;
            rst_done <= done_n;
        end
    end

    // Next-state and next-output logic. 'start' releases bit 0 and opens
    // the gap sequence; it is shared by the SYNC exit and the HOLD exit.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        cnt_n   = cnt;
        rel_n   = sync_rst;
        done_n  = rst_done;
        start   = 1'b0;
        case (state)
            SYNC: begin
                if (!rst_s) start = 1'b1;
            end
            RELEASE: begin
                if (cnt == GAP_M1) begin
                    cnt_n = '0;
                    ch_n  = ch + 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch == CHW'(k)) rel_n[k] = 1'b0;
                    end
                    if (ch == LAST_CH) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
`ifdef RST_SEQ_SW_REQ_EN
                // Software reset re-asserts every output; synchronizer untouched.
                if (sw_rst_req) begin
                    state_n = HOLD;
                    rel_n   = '1;
                    done_n  = 1'b0;
                    ch_n    = '0;
                    cnt_n   = '0;
                end
`endif
            end
`ifdef RST_SEQ_SW_REQ_EN
            HOLD: begin
                if (cnt == SWH_M1) start = 1'b1;
                else               cnt_n = cnt + 1'b1;
            end
`endif
            default: state_n = SYNC;
        endcase
        if (start) begin
            rel_n[0] = 1'b0;
            ch_n     = CHW'(1);
            cnt_n    = '0;
            if (NUM_CH == 1) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = RELEASE;
            end
        end
    end

endmodule

// File: tb/tb_rst_seq_sync.sv
// Testbench for rst_seq_sync: a default-parameter instance and a
// NUM_CH=1/GAP=1 corner instance share clk and rst. Expected outputs come
// from an edge-count model: each instance has a release start edge t0,
// and bit k is released once the edge count reaches t0 + k*GAP.
module tb_rst_seq_sync;

    localparam int NSTG = 2;
    localparam int NCH  = 4;
    localparam int GAPA = 8;
    localparam int SWH  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sw  = 1'b0;
    logic [NCH-1:0] sync_a;
    logic           done_a;
    logic [0:0]     sync_b;
    logic           done_b;

    int compared   = 0;
    int mismatched = 0;

    // Model state: edge count since time zero (non-reset edges), edges
    // since the last rst release, and the release start edge per instance.
    int e   = 0;
    int sc  = 0;
    int t0a = -1;
    int t0b = -1;

    always #5 clk = ~clk;

    rst_seq_sync #(.NUM_STG(NSTG), .NUM_CH(NCH), .GAP(GAPA), .SW_HOLD(SWH)) dut_a (
        .clk(clk),
        .rst(rst),
`ifdef RST_SEQ_SW_REQ_EN
        .sw_rst_req(sw),
`endif
        .sync_rst(sync_a),
        .rst_done(done_a)
    );

    rst_seq_sync #(.NUM_STG(NSTG), .NUM_CH(1), .GAP(1), .SW_HOLD(1)) dut_b (
        .clk(clk),
        .rst(rst),
`ifdef RST_SEQ_SW_REQ_EN
        .sw_rst_req(1'b0),
`endif
        .sync_rst(sync_b),
        .rst_done(done_b)
    );

    function automatic logic [15:0] exp_bits(int ec, int t0, int nch, int gap);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < nch; k++)
            r[k] = !(t0 >= 0 && ec >= t0 + k * gap);
        return r;
    endfunction

    function automatic logic exp_done(int ec, int t0, int nch, int gap);
        return (t0 >= 0 && ec >= t0 + (nch - 1) * gap);
    endfunction

    // Reference model: rst clears everything; the third clean edge after
    // release starts the sequence; a request seen while done restarts it
    // SW_HOLD edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sc  <= 0;
            t0a <= -1;
            t0b <= -1;
        end else begin
            e <= e + 1;
            if (sc < 1000) sc <= sc + 1;
            if (sc + 1 == NSTG + 1) begin
                t0a <= e + 1;
                t0b <= e + 1;
            end else if (sw && exp_done(e, t0a, NCH, GAPA)) begin
                t0a <= e + 1 + SWH;
            end
        end
    end

    task automatic check(string tag);
        logic [15:0] ea, eb;
        logic [NCH-1:0] xa;
        logic [0:0] xb;
        logic da, db;
        ea = exp_bits(e, t0a, NCH, GAPA);
        eb = exp_bits(e, t0b, 1, 1);
        xa = ea[NCH-1:0];
        xb = eb[0:0];
        da = exp_done(e, t0a, NCH, GAPA);
        db = exp_done(e, t0b, 1, 1);
        compared++;
        assert (sync_a === xa) else begin
            mismatched++;
            $error("FAIL %s sync_rst_a observed %b expected %b (edge %0d)", tag, sync_a, xa, e);
        end
        compared++;
        assert (done_a === da) else begin
            mismatched++;
            $error("FAIL %s rst_done_a observed %b expected %b (edge %0d)", tag, done_a, da, e);
        end
        compared++;
        assert (sync_b === xb) else begin
            mismatched++;
            $error("FAIL %s sync_rst_b observed %b expected %b (edge %0d)", tag, sync_b, xb, e);
        end
        compared++;
        assert (done_b === db) else begin
            mismatched++;
            $error("FAIL %s rst_done_b observed %b expected %b (edge %0d)", tag, done_b, db, e);
        end
    endtask

    task automatic step(int n, string tag);
        repeat (n) begin
            @(negedge clk);
            check(tag);
        end
    endtask

    // Sub-cycle rst pulse placed just after a falling edge, checked mid-pulse.
    task automatic glitch(string tag);
        #1 rst = 1'b1;
        #1 check(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Power-on: rst held 3 cycles, dropped 2 ns before the next edge.
        #1 rst = 1'b1;
        #1 check("reset_async");
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_hold");
        end
        #7 rst = 1'b0;
        step(32, "power_on");

        // Abort: sub-cycle pulse partway through the release sequence.
        rst = 1'b1;
        #2 rst = 1'b0;
        step(12, "pre_abort");
        glitch("abort_pulse");
        step(32, "abort_restart");

`ifdef RST_SEQ_SW_REQ_EN
        // Single-cycle software request in DONE.
        sw = 1'b1;
        step(1, "sw_assert");
        sw = 1'b0;
        step(32, "sw_release");

        // Request pulsed during release: ignored.
        rst = 1'b1;
        step(2, "rst_again");
        rst = 1'b0;
        step(14, "pre_ignored");
        sw = 1'b1;
        step(1, "ignored_req");
        sw = 1'b0;
        step(20, "ignored_tail");

        // Request held high across DONE entry retriggers.
        sw = 1'b1;
        step(80, "held_req");
        sw = 1'b0;
        step(40, "held_release");

        // rst and request together in DONE: rst wins.
        sw  = 1'b1;
        rst = 1'b1;
        step(2, "simul_rst");
        sw  = 1'b0;
        rst = 1'b0;
        step(32, "simul_after");
`endif

        // Randomized phase: request levels, glitches and multi-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            check("random");
`ifdef RST_SEQ_SW_REQ_EN
            if ($urandom_range(0, 9) == 0) sw = ~sw;
`endif
            if ($urandom_range(0, 149) == 0) begin
                glitch("rand_glitch");
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                step(int'($urandom_range(1, 4)), "rand_rst");
                rst = 1'b0;
            end
        end
        sw = 1'b0;
        step(100, "quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
